// File: rtl/pipe_frontend_regs_pkg.sv
// Shared constants and watchdog state type for the pipeline front-end registers.
package pipe_frontend_regs_pkg;

  localparam int unsigned CTRL_W_DEF = 8;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned STAT_W     = 16;

  // All-zero instruction word and control word both mean "no operation".
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    WD_RUN   = 2'd0,
    WD_STALL = 2'd1,
    WD_ERR   = 2'd2
  } wd_state_e;

endpackage

// File: rtl/pipe_frontend_regs_pipe_reg.sv
// Synchronous register with load enable and a clear that loads CLR_VAL; clear wins over load.
module pipe_reg #(
  parameter int unsigned  W       = 32,
  parameter logic [W-1:0] CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] data_d;
  logic [W-1:0] data_q;

  always_comb begin
    data_d = data_q;
    if (clr) begin
      data_d = CLR_VAL;
    end else if (load) begin
      data_d = d;
    end
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/pipe_frontend_regs.sv
// PC, IF/ID and ID/EX slice registers driven by hazard-unit stall/bubble controls and branch flush,
// with a saturating bubble counter and a sticky consecutive-stall watchdog.
module pipe_frontend_regs
  import pipe_frontend_regs_pkg::*;
#(
  parameter int unsigned      WIDTH       = 32,
  parameter int unsigned      CTRL_W      = CTRL_W_DEF,
  parameter logic [WIDTH-1:0] PC_RESET    = '0,
  parameter int unsigned      PC_STEP     = 4,
  parameter int unsigned      STALL_LIMIT = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pc_write,
  input  logic                  ifid_write,
  input  logic                  hazard_mux,
  input  logic                  flush,
  input  logic [WIDTH-1:0]      branch_target,
  input  logic [WIDTH-1:0]      instr_in,
  input  logic [CTRL_W-1:0]     ctrl_in,
  input  logic [REG_ADDR_W-1:0] rd_in,
  input  logic                  regwrite_in,
  output logic [WIDTH-1:0]      pc,
  output logic [WIDTH-1:0]      ifid_instr,
  output logic [WIDTH-1:0]      ifid_pc,
  output logic                  ifid_valid,
  output logic [CTRL_W-1:0]     idex_ctrl,
  output logic [REG_ADDR_W-1:0] idex_rd,
  output logic                  idex_regwrite,
  output logic                  idex_valid,
  output logic [STAT_W-1:0]     stall_cnt,
  output logic                  stall_err
);

  localparam int unsigned RUN_W_RAW = $clog2(STALL_LIMIT + 1);
  localparam int unsigned RUN_W     = (RUN_W_RAW < 2) ? 2 : RUN_W_RAW;
  localparam int unsigned IFID_W    = 2 * WIDTH + 1;
  localparam int unsigned IDEX_W    = CTRL_W + REG_ADDR_W + 2;

  localparam logic [WIDTH-1:0]  NOP_W     = WIDTH'(NOP_INSTR);
  localparam logic [IFID_W-1:0] IFID_CLR  = {NOP_W, {WIDTH{1'b0}}, 1'b0};
  localparam logic [RUN_W-1:0]  RUN_LIMIT = RUN_W'(STALL_LIMIT);
  localparam logic [STAT_W-1:0] CNT_MAX   = '1;

  logic bubble_c;
  logic slice_clr_c;

  assign bubble_c    = hazard_mux & ~flush;
  assign slice_clr_c = reset | flush;

  // Program counter: flush redirects regardless of pc_write.
  logic             pc_load_c;
  logic [WIDTH-1:0] pc_next_c;

  assign pc_load_c = flush | pc_write;
  assign pc_next_c = flush ? branch_target : pc + WIDTH'(PC_STEP);

  pipe_reg #(.W(WIDTH), .CLR_VAL(PC_RESET)) u_pc_reg (
    .clk  (clk),
    .clr  (reset),
    .load (pc_load_c),
    .d    (pc_next_c),
    .q    (pc)
  );

  logic [IFID_W-1:0] ifid_q;

  pipe_reg #(.W(IFID_W), .CLR_VAL(IFID_CLR)) u_ifid_reg (
    .clk  (clk),
    .clr  (slice_clr_c),
    .load (ifid_write),
    .d    ({instr_in, pc, 1'b1}),
    .q    (ifid_q)
  );

  assign {ifid_instr, ifid_pc, ifid_valid} = ifid_q;

  // ID/EX loads every cycle; a bubble is simply an all-zero slice.
  logic [IDEX_W-1:0] idex_next_c;
  logic [IDEX_W-1:0] idex_q;

  assign idex_next_c = hazard_mux ? '0
                     : {ctrl_in, rd_in, regwrite_in & ifid_valid, ifid_valid};

  pipe_reg #(.W(IDEX_W), .CLR_VAL('0)) u_idex_reg (
    .clk  (clk),
    .clr  (slice_clr_c),
    .load (1'b1),
    .d    (idex_next_c),
    .q    (idex_q)
  );

  assign {idex_ctrl, idex_rd, idex_regwrite, idex_valid} = idex_q;

  // Bubble statistics and watchdog.
  wd_state_e         state_d, state_q;
  logic [RUN_W-1:0]  run_d, run_q;
  logic [STAT_W-1:0] stall_cnt_d, stall_cnt_q;
  logic              stall_err_d, stall_err_q;
  logic [RUN_W-1:0]  run_inc_c;

  assign run_inc_c = (run_q >= RUN_LIMIT) ? run_q : run_q + RUN_W'(1);

  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    stall_cnt_d = stall_cnt_q;
    stall_err_d = stall_err_q;

    if (bubble_c) begin
      run_d = run_inc_c;
      if (stall_cnt_q != CNT_MAX) begin
        stall_cnt_d = stall_cnt_q + STAT_W'(1);
      end
    end else begin
      run_d = '0;
    end

    unique case (state_q)
      WD_RUN, WD_STALL: begin
        if (bubble_c) begin
          if (run_inc_c >= RUN_LIMIT) begin
            state_d     = WD_ERR;
            stall_err_d = 1'b1;
          end else begin
            state_d = WD_STALL;
          end
        end else begin
          state_d = WD_RUN;
        end
      end
      WD_ERR: begin
        state_d     = WD_ERR;
        stall_err_d = 1'b1;
      end
      default: begin
        state_d = WD_RUN;
      end
    endcase

    if (reset) begin
      state_d     = WD_RUN;
      run_d       = '0;
      stall_cnt_d = '0;
      stall_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    state_q     <= state_d;
    run_q       <= run_d;
    stall_cnt_q <= stall_cnt_d;
    stall_err_q <= stall_err_d;
  end

  assign stall_cnt = stall_cnt_q;
  assign stall_err = stall_err_q;

endmodule

// File: tb/tb_pipe_frontend_regs.sv
// Directed self-checking bench for pipe_frontend_regs: advance, stall, flush, wrap, saturation, reset.
module tb_pipe_frontend_regs;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_write, ifid_write, hazard_mux, flush;
  logic [31:0] branch_target, instr_in;
  logic [7:0]  ctrl_in;
  logic [4:0]  rd_in;
  logic        regwrite_in;
  logic [31:0] pc, ifid_instr, ifid_pc;
  logic        ifid_valid;
  logic [7:0]  idex_ctrl;
  logic [4:0]  idex_rd;
  logic        idex_regwrite, idex_valid;
  logic [15:0] stall_cnt;
  logic        stall_err;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [31:0] INSTR_A = 32'h0000_0113;
  localparam logic [31:0] INSTR_B = 32'h0020_8233;
  localparam logic [31:0] INSTR_C = 32'h0041_0393;
  localparam logic [31:0] INSTR_D = 32'h0062_84B3;

  always #5 clk = ~clk;

  pipe_frontend_regs dut (
    .clk           (clk),
    .reset         (reset),
    .pc_write      (pc_write),
    .ifid_write    (ifid_write),
    .hazard_mux    (hazard_mux),
    .flush         (flush),
    .branch_target (branch_target),
    .instr_in      (instr_in),
    .ctrl_in       (ctrl_in),
    .rd_in         (rd_in),
    .regwrite_in   (regwrite_in),
    .pc            (pc),
    .ifid_instr    (ifid_instr),
    .ifid_pc       (ifid_pc),
    .ifid_valid    (ifid_valid),
    .idex_ctrl     (idex_ctrl),
    .idex_rd       (idex_rd),
    .idex_regwrite (idex_regwrite),
    .idex_valid    (idex_valid),
    .stall_cnt     (stall_cnt),
    .stall_err     (stall_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_free();
    pc_write = 1'b1; ifid_write = 1'b1; hazard_mux = 1'b0; flush = 1'b0;
  endtask

  task automatic full_stall();
    pc_write = 1'b0; ifid_write = 1'b0; hazard_mux = 1'b1; flush = 1'b0;
  endtask

  initial begin
    reset = 1'b1; branch_target = '0; instr_in = '0;
    ctrl_in = '0; rd_in = '0; regwrite_in = 1'b0;
    run_free();

    // Reset state
    tick(); tick();
    check("rst_pc", pc, 32'h0);
    check("rst_ifid_valid", 32'(ifid_valid), 32'h0);
    check("rst_ifid_instr", ifid_instr, 32'h0);
    check("rst_idex_valid", 32'(idex_valid), 32'h0);
    check("rst_stall_cnt", 32'(stall_cnt), 32'h0);
    check("rst_stall_err", 32'(stall_err), 32'h0);
    reset = 1'b0;

    // Three free cycles: A, B, C
    instr_in = INSTR_A; ctrl_in = 8'h11; rd_in = 5'd1; regwrite_in = 1'b1;
    tick();
    check("t1_pc4", pc, 32'd4);
    check("t1_idex_valid0", 32'(idex_valid), 32'h0);
    check("t1_idex_rw0", 32'(idex_regwrite), 32'h0);
    instr_in = INSTR_B; ctrl_in = 8'hA5; rd_in = 5'd4; regwrite_in = 1'b1;
    tick();
    check("t1_pc8", pc, 32'd8);
    check("t1_ifid_b", ifid_instr, INSTR_B);
    instr_in = INSTR_C; ctrl_in = 8'h3C; rd_in = 5'd7; regwrite_in = 1'b1;
    tick();
    check("t1_pc12", pc, 32'd12);
    check("t1_ifid_c", ifid_instr, INSTR_C);
    check("t1_ifid_pc", ifid_pc, 32'd8);
    check("t1_ifid_valid", 32'(ifid_valid), 32'h1);
    check("t1_idex_ctrl", 32'(idex_ctrl), 32'h3C);
    check("t1_idex_rd", 32'(idex_rd), 32'd7);
    check("t1_idex_rw", 32'(idex_regwrite), 32'h1);
    check("t1_idex_valid", 32'(idex_valid), 32'h1);

    // Single full stall, then resume
    full_stall(); instr_in = INSTR_D; ctrl_in = 8'h77; rd_in = 5'd9;
    tick();
    check("t2_pc_hold", pc, 32'd12);
    check("t2_ifid_hold", ifid_instr, INSTR_C);
    check("t2_idex_ctrl", 32'(idex_ctrl), 32'h0);
    check("t2_idex_rw", 32'(idex_regwrite), 32'h0);
    check("t2_idex_valid", 32'(idex_valid), 32'h0);
    check("t2_cnt", 32'(stall_cnt), 32'd1);
    run_free(); ctrl_in = 8'h5A; rd_in = 5'd3; regwrite_in = 1'b0;
    tick();
    check("t2_pc_resume", pc, 32'd16);
    check("t2_ifid_d", ifid_instr, INSTR_D);
    check("t2_ifid_pc", ifid_pc, 32'd12);
    check("t2_idex_ctrl_c", 32'(idex_ctrl), 32'h5A);
    check("t2_idex_valid1", 32'(idex_valid), 32'h1);
    check("t2_err", 32'(stall_err), 32'h0);

    // Two consecutive stalls are legal; the third trips the watchdog
    full_stall();
    tick(); tick();
    check("t3_cnt2", 32'(stall_cnt), 32'd3);
    check("t3_err_after2", 32'(stall_err), 32'h0);
    check("t3_pc_hold", pc, 32'd16);
    tick();
    check("t3_cnt3", 32'(stall_cnt), 32'd4);
    check("t3_err_after3", 32'(stall_err), 32'h1);
    run_free();
    for (int i = 0; i < 10; i++) tick();
    check("t3_err_sticky", 32'(stall_err), 32'h1);
    check("t3_pc_after10", pc, 32'd56);
    check("t3_cnt_clean", 32'(stall_cnt), 32'd4);

    // Flush while a full stall is requested
    full_stall(); flush = 1'b1; branch_target = 32'h40;
    tick();
    check("t4_pc", pc, 32'h40);
    check("t4_ifid_valid", 32'(ifid_valid), 32'h0);
    check("t4_ifid_instr", ifid_instr, 32'h0);
    check("t4_idex_valid", 32'(idex_valid), 32'h0);
    check("t4_idex_ctrl", 32'(idex_ctrl), 32'h0);
    check("t4_cnt", 32'(stall_cnt), 32'd4);

    // PC wrap-around
    run_free(); flush = 1'b1; branch_target = 32'hFFFF_FFFC;
    tick();
    check("t5_pc_top", pc, 32'hFFFF_FFFC);
    run_free();
    tick();
    check("t5_pc_wrap", pc, 32'h0);

    // Bubble counter saturation: 4 + 65530 = 65534, then 65535, then held
    full_stall();
    for (int i = 0; i < 65530; i++) tick();
    check("t5_cnt_near", 32'(stall_cnt), 32'd65534);
    tick();
    check("t5_cnt_max", 32'(stall_cnt), 32'h0000_FFFF);
    for (int i = 0; i < 5; i++) tick();
    check("t5_cnt_sat", 32'(stall_cnt), 32'h0000_FFFF);

    // Reset during a stall
    reset = 1'b1;
    tick();
    check("t6_pc", pc, 32'h0);
    check("t6_ifid_valid", 32'(ifid_valid), 32'h0);
    check("t6_idex_valid", 32'(idex_valid), 32'h0);
    check("t6_cnt", 32'(stall_cnt), 32'h0);
    check("t6_err", 32'(stall_err), 32'h0);
    reset = 1'b0; run_free();
    tick();
    check("t6_pc_restart", pc, 32'd4);
    check("t6_err_clean", 32'(stall_err), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
